sha256: RTL and testbench

// - Streaming SHA-256 hasher (FIPS 180-4). Accepts the message as 32-bit big-endian words.
// - Pads the message internally and outputs the 256-bit digest.
// - Sits between a word-oriented data source and any consumer of the digest.
// - Hashes one message per reset; rounds are iterative.

---
 rtl/sha256_pkg.sv | 76 +++++++
 rtl/sha256_round.sv | 27 ++
 rtl/sha256.sv | 164 ++++++++++++++++
 tb/tb_sha256.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared constants, types and bit-mixing functions for the SHA-256 core.
package sha256_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned STATE_W = 256;

    typedef enum logic [1:0] {LOAD, PAD, COMP, DONE} state_e;

    // Working variables a..h; a lands in the most significant word.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } sha_state_t;

    localparam sha_state_t H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, y, z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, y, z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 5'd2) ^ rotr(x, 5'd13) ^ rotr(x, 5'd22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 5'd6) ^ rotr(x, 5'd11) ^ rotr(x, 5'd25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 5'd7) ^ rotr(x, 5'd18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 5'd17) ^ rotr(x, 5'd19) ^ (x >> 10);
    endfunction

    function automatic sha_state_t add_state(input sha_state_t x, y);
        sha_state_t r;
        r.a = x.a + y.a;
        r.b = x.b + y.b;
        r.c = x.c + y.c;
        r.d = x.d + y.d;
        r.e = x.e + y.e;
        r.f = x.f + y.f;
        r.g = x.g + y.g;
        r.h = x.h + y.h;
        return r;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
module sha256_round
    import sha256_pkg::*;
(
    input  sha_state_t  s_i,
    input  logic [31:0] w_i,
    input  logic [31:0] k_i,
    output sha_state_t  s_o
);

    logic [31:0] t1_c;
    logic [31:0] t2_c;

    always_comb begin
        t1_c   = s_i.h + big_sigma1(s_i.e) + ch(s_i.e, s_i.f, s_i.g) + k_i + w_i;
        t2_c   = big_sigma0(s_i.a) + maj(s_i.a, s_i.b, s_i.c);
        s_o.a  = t1_c + t2_c;
        s_o.b  = s_i.a;
        s_o.c  = s_i.b;
        s_o.d  = s_i.c;
        s_o.e  = s_i.d + t1_c;
        s_o.f  = s_i.e;
        s_o.g  = s_i.f;
        s_o.h  = s_i.g;
    end

endmodule

// File: rtl/sha256.sv
// Streaming single-message SHA-256 hasher with internal padding.
// Define SHA256_UNROLL2_EN to run two rounds per clock (32-cycle compression).
module sha256
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  input_data,
    input  logic         input_valid,
    output logic         input_ready,
    input  logic         last_word,
    input  logic [1:0]   last_numbyte,
    output logic         output_valid,
    output logic [255:0] hash_data
);

`ifdef SHA256_UNROLL2_EN
    localparam int unsigned STEP     = 2;
    localparam logic [5:0]  LAST_RND = 6'd62;
`else
    localparam int unsigned STEP     = 1;
    localparam logic [5:0]  LAST_RND = 6'd63;
`endif

    state_e      state_q;
    logic [31:0] w_q [16];
    logic [3:0]  widx_q;
    logic [5:0]  rnd_q;
    logic [63:0] len_q;
    sha_state_t  h_q;
    sha_state_t  v_q;
    logic        last_seen_q, sep_done_q, len_hi_q, len_done_q;
    logic        in_ready_q, out_valid_q;
    logic [255:0] hash_q;

    logic [31:0] in_word_c, pad_word_c, new16_c, new17_c;
    logic [63:0] len_inc_c;
    sha_state_t  r1_c, step_c, h_sum_c;

    assign input_ready  = in_ready_q;
    assign output_valid = out_valid_q;
    assign hash_data    = hash_q;

    // Mask the final word and place the 0x80 separator right after its last valid byte.
    always_comb begin
        in_word_c = input_data;
        len_inc_c = 64'd32;
        if (last_word) begin
            case (last_numbyte)
                2'd1:    in_word_c = {input_data[31:24], 8'h80, 16'h0000};
                2'd2:    in_word_c = {input_data[31:16], 8'h80, 8'h00};
                2'd3:    in_word_c = {input_data[31:8], 8'h80};
                default: in_word_c = input_data;
            endcase
            if (last_numbyte != 2'd0) len_inc_c = 64'({last_numbyte, 3'b000});
        end
    end

    always_comb begin
        pad_word_c = 32'h0;
        if (!sep_done_q)                      pad_word_c = 32'h8000_0000;
        else if (widx_q == 4'd14)             pad_word_c = len_q[63:32];
        else if (widx_q == 4'd15 && len_hi_q) pad_word_c = len_q[31:0];
    end

    assign new16_c = small_sigma1(w_q[14]) + w_q[9]  + small_sigma0(w_q[1]) + w_q[0];
    assign new17_c = small_sigma1(w_q[15]) + w_q[10] + small_sigma0(w_q[2]) + w_q[1];

    sha256_round u_round0 (.s_i(v_q), .w_i(w_q[0]), .k_i(K[rnd_q]), .s_o(r1_c));

`ifdef SHA256_UNROLL2_EN
    sha_state_t r2_c;
    sha256_round u_round1 (.s_i(r1_c), .w_i(w_q[1]), .k_i(K[6'(rnd_q + 6'd1)]), .s_o(r2_c));
    assign step_c = r2_c;
`else
    assign step_c = r1_c;
`endif

    assign h_sum_c = add_state(h_q, step_c);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LOAD;
            for (int i = 0; i < 16; i++) w_q[i] <= 32'h0;
            widx_q      <= 4'd0;
            rnd_q       <= 6'd0;
            len_q       <= 64'd0;
            h_q         <= H0;
            v_q         <= H0;
            last_seen_q <= 1'b0;
            sep_done_q  <= 1'b0;
            len_hi_q    <= 1'b0;
            len_done_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            hash_q      <= '0;
        end else begin
            case (state_q)
                LOAD: if (input_valid && in_ready_q) begin
                    w_q[widx_q] <= in_word_c;
                    len_q       <= len_q + len_inc_c;
                    widx_q      <= widx_q + 4'd1;
                    if (last_word) begin
                        last_seen_q <= 1'b1;
                        sep_done_q  <= (last_numbyte != 2'd0);
                    end
                    if (widx_q == 4'd15) begin
                        state_q    <= COMP;
                        rnd_q      <= 6'd0;
                        v_q        <= h_q;
                        in_ready_q <= 1'b0;
                    end else if (last_word) begin
                        state_q    <= PAD;
                        in_ready_q <= 1'b0;
                    end
                end
                PAD: begin
                    w_q[widx_q] <= pad_word_c;
                    widx_q      <= widx_q + 4'd1;
                    if (!sep_done_q) sep_done_q <= 1'b1;
                    else if (widx_q == 4'd14) len_hi_q <= 1'b1;
                    else if (widx_q == 4'd15 && len_hi_q) len_done_q <= 1'b1;
                    if (widx_q == 4'd15) begin
                        state_q <= COMP;
                        rnd_q   <= 6'd0;
                        v_q     <= h_q;
                    end
                end
                COMP: begin
                    v_q   <= step_c;
                    rnd_q <= rnd_q + 6'(STEP);
`ifdef SHA256_UNROLL2_EN
                    for (int i = 0; i < 14; i++) w_q[i] <= w_q[i+2];
                    w_q[14] <= new16_c;
                    w_q[15] <= new17_c;
`else
                    for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                    w_q[15] <= new16_c;
`endif
                    if (rnd_q == LAST_RND) begin
                        h_q      <= h_sum_c;
                        widx_q   <= 4'd0;
                        len_hi_q <= 1'b0;
                        if (!last_seen_q) begin
                            state_q    <= LOAD;
                            in_ready_q <= 1'b1;
                        end else if (!len_done_q) begin
                            state_q <= PAD;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            hash_q      <= h_sum_c;
                        end
                    end
                end
                DONE: ;
            endcase
        end
    end

    logic unused_c;
    assign unused_c = ^new17_c;

endmodule

// File: tb/tb_sha256.sv
// Directed self-checking bench for the sha256 streaming hasher.
module tb_sha256;

    logic         clk;
    logic         rst;
    logic [31:0]  input_data;
    logic         input_valid;
    logic         input_ready;
    logic         last_word;
    logic [1:0]   last_numbyte;
    logic         output_valid;
    logic [255:0] hash_data;

    int tests;
    int fails;
    int lat;

    localparam logic [255:0] HASH_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] HASH_ABCD = 256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589;
    localparam logic [255:0] HASH_56   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
`ifdef SHA256_UNROLL2_EN
    localparam int EXP_LAT = 47;
`else
    localparam int EXP_LAT = 79;
`endif

    logic [31:0] msg56 [14] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                32'h6d6e6f70, 32'h6e6f7071};

    sha256 dut (
        .clk          (clk),
        .rst          (rst),
        .input_data   (input_data),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .last_word    (last_word),
        .last_numbyte (last_numbyte),
        .output_valid (output_valid),
        .hash_data    (hash_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        input_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Present one word and hold it until the transfer edge.
    task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] n);
        int waited;
        waited = 0;
        @(negedge clk);
        input_data   = d;
        last_word    = l;
        last_numbyte = n;
        input_valid  = 1'b1;
        while (!input_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) check("ready_timeout", 256'(input_ready), 256'(1));
        @(posedge clk);
        #1;
        input_valid = 1'b0;
        last_word   = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!output_valid && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!output_valid) check("done_timeout", 256'(output_valid), 256'(1));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        input_data = 32'h0;
        input_valid = 1'b0;
        last_word = 1'b0;
        last_numbyte = 2'd0;
        #12;
        check("reset_ready", 256'(input_ready), 256'(1));
        check("reset_valid", 256'(output_valid), 256'(0));
        check("reset_hash", hash_data, 256'(0));
        @(negedge clk);
        rst = 1'b1;

        // "abc" in one word, then latency and post-DONE behaviour
        send_word(32'h61626300, 1'b1, 2'd3);
        check("abc_ready_low", 256'(input_ready), 256'(0));
        wait_done(lat);
        check("abc_hash", hash_data, HASH_ABC);
        check("abc_latency", 256'(lat), 256'(EXP_LAT));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            input_data  = 32'hdead0000 | 32'(i);
            input_valid = 1'b1;
            last_word   = i[0];
        end
        @(negedge clk);
        input_valid = 1'b0;
        check("done_valid_hold", 256'(output_valid), 256'(1));
        check("done_hash_hold", hash_data, HASH_ABC);
        check("done_ready_low", 256'(input_ready), 256'(0));

        // "abcd": full final word, separator spills into the next word
        do_reset();
        send_word(32'h61626364, 1'b1, 2'd0);
        wait_done(lat);
        check("abcd_hash", hash_data, HASH_ABCD);

        // 56-byte message needs a second padding block
        do_reset();
        for (int i = 0; i < 14; i++) send_word(msg56[i], i == 13, 2'd0);
        wait_done(lat);
        check("msg56_hash", hash_data, HASH_56);

        // Same message with 5 idle cycles before every word
        do_reset();
        for (int i = 0; i < 14; i++) begin
            repeat (5) @(negedge clk);
            send_word(msg56[i], i == 13, 2'd0);
        end
        wait_done(lat);
        check("msg56_gaps_hash", hash_data, HASH_56);

        // "abc" after a stall, with garbage in the ignored trailing byte
        do_reset();
        repeat (5) @(negedge clk);
        send_word(32'h616263ff, 1'b1, 2'd3);
        wait_done(lat);
        check("abc_masked_hash", hash_data, HASH_ABC);

        // Abort during compression, then hash again from scratch
        do_reset();
        send_word(32'h61626300, 1'b1, 2'd3);
        repeat (30) @(posedge clk);
        #3;
        check("pre_abort_valid", 256'(output_valid), 256'(0));
        rst = 1'b0;
        #1;
        check("abort_valid", 256'(output_valid), 256'(0));
        check("abort_ready", 256'(input_ready), 256'(1));
        check("abort_hash", hash_data, 256'(0));
        @(negedge clk);
        rst = 1'b1;
        send_word(32'h61626300, 1'b1, 2'd3);
        wait_done(lat);
        check("abort_rerun_hash", hash_data, HASH_ABC);
        check("abort_rerun_latency", 256'(lat), 256'(EXP_LAT));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
